// File: rtl/fft_host_ctrl_if.sv
// fft_host_ctrl_if
//   Bundles the streaming sample input, the streaming bin output and the
//   FFT core memory/control port of fft_host_ctrl.
//   master : the controller side (fft_host_ctrl itself)
//   slave  : the environment side (sample source, bin sink, FFT core)
//   Parameters: LOGN = log2 of transform length, CW = complex word width.
interface fft_host_ctrl_if #(
    parameter int LOGN = 10,
    parameter int CW   = 64
);
    logic            s_valid;
    logic            s_ready;
    logic [CW-1:0]   s_data;
    logic            m_valid;
    logic            m_ready;
    logic [CW-1:0]   m_data;
    logic            m_last;
    logic            fft_we;
    logic            fft_rev;
    logic [LOGN-1:0] fft_addr;
    logic [CW-1:0]   fft_din;
    logic [CW-1:0]   fft_dout;
    logic            fft_sig;
    logic            fft_done;
    logic            err;

    modport master (
        input  s_valid, s_data, m_ready, fft_dout, fft_done,
        output s_ready, m_valid, m_data, m_last,
               fft_we, fft_rev, fft_addr, fft_din, fft_sig, err
    );

    modport slave (
        output s_valid, s_data, m_ready, fft_dout, fft_done,
        input  s_ready, m_valid, m_data, m_last,
               fft_we, fft_rev, fft_addr, fft_din, fft_sig, err
    );
endinterface

// File: rtl/fft_host_ctrl.sv
// fft_host_ctrl
//   Host-side sequencer for an in-place FFT core. Streams N samples into the
//   core memory (bit-reversed addressing), pulses the core start, waits for
//   completion under a watchdog, then reads the N bins back in natural order
//   through a 2-entry skid FIFO onto a valid/ready output stream.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : fft_host_ctrl_if.master (sample in, bin out, core port, err)
//   Parameters: LOGN (log2 N), CW (complex word width), TMO (watchdog cycles)
module fft_host_ctrl #(
    parameter int LOGN = 10,
    parameter int CW   = 64,
    parameter int TMO  = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_host_ctrl_if.master bus
);
    localparam int              N        = 1 << LOGN;
    localparam int              WDW      = $clog2(TMO + 1);
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        READ,
        DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] rp;
    logic [WDW-1:0]  wd;
    logic            err_q;

    // Read issued last cycle: its data is on fft_dout this cycle.
    logic            rd_pend;
    logic            rd_pend_last;

    logic [CW-1:0]   fifo_data [2];
    logic            fifo_last [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      occ;

    logic            load_hs;
    logic            rd_issue;
    logic            wd_expire;
    logic            push;
    logic            pop;

    assign push        = rd_pend;
    assign pop         = bus.m_valid && bus.m_ready;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = fifo_data[rd_ptr];
    assign bus.m_last  = (occ != 2'd0) && fifo_last[rd_ptr];
    assign bus.err     = err_q;

    always_comb begin
        state_nxt    = state;
        bus.s_ready  = 1'b0;
        bus.fft_we   = 1'b0;
        bus.fft_rev  = 1'b0;
        bus.fft_addr = '0;
        bus.fft_din  = '0;
        bus.fft_sig  = 1'b0;
        load_hs      = 1'b0;
        rd_issue     = 1'b0;
        wd_expire    = 1'b0;
        case (state)
            IDLE: state_nxt = LOAD;
            LOAD: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    load_hs      = 1'b1;
                    bus.fft_we   = 1'b1;
                    bus.fft_rev  = 1'b1;
                    bus.fft_addr = cnt;
                    bus.fft_din  = bus.s_data;
                    if (cnt == LAST_IDX) begin
                        state_nxt = START;
                    end
                end
            end
            START: begin
                bus.fft_sig = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (bus.fft_done) begin
                    state_nxt = READ;
                end else if (wd == WD_LIMIT) begin
                    wd_expire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            READ: begin
                bus.fft_addr = rp;
                // Only issue when, after this cycle's push/pop, the FIFO can
                // still absorb next cycle's returning word without a pop.
                if (({1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop}) < 3'd2) begin
                    rd_issue = 1'b1;
                    if (rp == LAST_IDX) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && bus.m_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt and rp are LOGN bits wide, so incrementing past N-1 wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rp           <= '0;
            wd           <= '0;
            err_q        <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            state        <= state_nxt;
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (rp == LAST_IDX);
            if (load_hs) begin
                cnt <= cnt + 1'b1;
            end
            if (rd_issue) begin
                rp <= rp + 1'b1;
            end
            if (state == START) begin
                wd <= '0;
            end else if (state == WAIT) begin
                wd <= wd + 1'b1;
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= bus.fft_dout;
                fifo_last[wr_ptr] <= rd_pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: doc/fft_host_ctrl.md
FFT_HOST_CTRL -- requirements
Module: fft_host_ctrl

Interface
REQ-001 The block SHALL have parameter LOGN, default 10, meaning log2 of transform length N.
REQ-002 The block SHALL have parameter CW, default 64, meaning complex word width: {real[CW/2-1:0] float, imag float}.
REQ-003 The block SHALL have parameter TMO, default 65535, meaning the completion watchdog limit in clk cycles.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid&s_ready.
- s_data  in  CW  input sample, natural time order.
- m_valid  out  1  output bin valid.
- m_ready  in  1  downstream accepts the bin.
- m_data  out  CW  output bin, natural frequency order.
- m_last  out  1  high with bin N-1.
- fft_we  out  1  FFT core memory write enable.
- fft_rev  out  1  FFT core bit-reversed addressing select.
- fft_addr  out  LOGN  FFT core memory address.
- fft_din  out  CW  FFT core write data.
- fft_dout  in  CW  FFT core read data, valid 1 cycle after fft_addr.
- fft_sig  out  1  FFT start pulse.
- fft_done  in  1  FFT finish pulse.
- err  out  1  sticky watchdog error.

Function
REQ-005 The block SHALL implement states IDLE, LOAD, START, WAIT, READ and DRAIN as a registered FSM.
REQ-006 IDLE SHALL go to LOAD unconditionally on the next cycle; s_ready=0 in IDLE.
REQ-007 In LOAD, s_ready SHALL be 1, and each handshake SHALL drive fft_we=1, fft_rev=1, fft_addr=cnt and fft_din=s_data in the same cycle, then increment cnt.
REQ-008 The handshake at cnt=N-1 SHALL wrap cnt to 0 and move the FSM to START.
REQ-009 fft_we SHALL be 0 whenever no LOAD handshake occurs.
REQ-010 START SHALL assert fft_sig for exactly one cycle, clear the watchdog counter, and go to WAIT.
REQ-011 In WAIT, fft_addr, fft_we and fft_din SHALL be held at 0, and s_ready SHALL be 0.
- fft_done=1 SHALL go to READ.
- Watchdog reaching TMO SHALL set err=1 and go to IDLE.
REQ-012 In READ, fft_rev SHALL be 0 and fft_addr SHALL be the read pointer rp.
- rp SHALL advance only when the 2-entry output skid FIFO has room for the in-flight word.
- Each read SHALL push fft_dout into the FIFO one cycle later.
REQ-013 The block SHALL tag the word read at rp=N-1 with last=1; after issuing that read the FSM SHALL go to DRAIN.
REQ-014 DRAIN SHALL return to IDLE, with rp=0, when the last word is popped (m_valid&m_ready&m_last).
REQ-015 m_valid SHALL be driven from FIFO non-empty, and m_data/m_last from the FIFO head.
- m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-016 With m_ready held at 1, throughput SHALL be 1 bin per cycle; first m_valid SHALL occur 2 cycles after entering READ.
REQ-017 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; a push SHALL never be issued when occupancy is 2 and no pop occurs.
REQ-018 fft_done outside WAIT SHALL be ignored; s_valid outside LOAD SHALL be ignored (not consumed).
REQ-019 err SHALL clear only on reset.

Reset
REQ-020 While rst_n=0, the block SHALL hold state=IDLE, cnt=rp=0, FIFO empty, and watchdog=0.
- Outputs SHALL be: s_ready=0, m_valid=0, m_last=0, fft_we=0, fft_sig=0, fft_rev=0, fft_addr=0, fft_din=0, m_data=0, err=0.
REQ-021 Reset asserted mid-LOAD, WAIT or READ SHALL abort immediately, with no further fft_we or fft_sig.
REQ-022 After rst_n rises, the block SHALL enter LOAD within 1 cycle.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with LOGN=3:
- Full pass: stream 8 samples 0..7 → fft_we with fft_rev=1 at addr 0..7, one fft_sig pulse; done after 20 cycles → 8 bins in addr order 0..7 with m_last on the 8th.
- Backpressure: m_ready toggled 1,0,0,1 repeatedly → no bin lost or duplicated, m_data stable during stalls, occupancy ≤2.
- Input gaps: s_valid random 50% → addresses still 0..7 contiguous, fft_sig only after the 8th accept.
- Timeout: TMO=10, fft_done never → err=1 at cycle 10 of WAIT, state returns to IDLE/LOAD, err stays 1.
- Reset mid-READ after 3 bins → all outputs 0 within the reset, next frame loads at addr 0.
- Spurious fft_done during LOAD → ignored; FSM stays in LOAD until 8 accepts.
